// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with valid/ready flow control.
// Optional accumulate mode folds a multi-beat burst into one result.
module bitwise_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_last
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             last_q, last_d;

  logic             accept;
  logic [WIDTH-1:0] f_new;
  logic [WIDTH-1:0] f_acc;

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (sel)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x | y);
      3'd4: r = ~(x & y);
      3'd5: r = ~(x ^ y);
      3'd6: r = x & ~y;
      3'd7: r = x | ~y;
    endcase
    return r;
  endfunction

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_last   = last_q;

  always_comb begin
    f_new       = logic_op(op, a, b);
    f_acc       = logic_op(op_q, acc_q, b);
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    last_d      = last_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (acc_mode && !in_last) begin
            state_d = ACCUM;
            acc_d   = f_new;
            op_d    = op;
          end else begin
            out_valid_d = 1'b1;
            res_d       = f_new;
            zero_d      = (f_new == '0);
            last_d      = in_last;
          end
        end
        ACCUM: begin
          // a, op and acc_mode are don't-care once a burst is open
          if (!in_last) begin
            acc_d = f_acc;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            res_d       = f_acc;
            zero_d      = (f_acc == '0);
            last_d      = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit (WIDTH=8).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_bitwise_logic_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         acc_mode = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_last;

  int errs = 0;
  int checks = 0;

  bitwise_logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fm(input int o, input int x, input int y);
    int r;
    case (o)
      0: r = x & y;
      1: r = x | y;
      2: r = x ^ y;
      3: r = ~(x | y);
      4: r = ~(x & y);
      5: r = ~(x ^ y);
      6: r = x & ~y;
      default: r = x | ~y;
    endcase
    return r & 'hFF;
  endfunction

  // Behavioural model: held output, open-burst flag, accumulator
  bit m_valid = 0;
  int m_res = 0;
  bit m_zero = 0;
  bit m_last = 0;
  bit m_open = 0;
  int m_acc = 0;
  int m_op = 0;

  // Handshaked outputs as {last, zero, result}
  logic [9:0] got[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_res = 0; m_zero = 0; m_last = 0;
      m_open = 0; m_acc = 0; m_op = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_result", int'(out_result), 0);
      chk("rst_out_zero", int'(out_zero), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_in_ready", int'(in_ready), 1);
    end else begin
      bit rdy;
      bit emit;
      int r;
      bit l;
      chk("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("out_result", int'(out_result), m_res);
        chk("out_zero", int'(out_zero), int'(m_zero));
        chk("out_last", int'(out_last), int'(m_last));
      end
      rdy = !m_valid || out_ready;
      chk("in_ready", int'(in_ready), int'(rdy));
      if (out_valid && out_ready)
        got.push_back({out_last, out_zero, out_result});
      emit = 0; r = 0; l = 0;
      if (in_valid && rdy) begin
        if (!m_open) begin
          r = fm(int'(op), int'(a), int'(b));
          if (acc_mode && !in_last) begin
            m_open = 1; m_acc = r; m_op = int'(op);
          end else begin
            emit = 1; l = in_last;
          end
        end else begin
          r = fm(m_op, m_acc, int'(b));
          if (!in_last) m_acc = r;
          else begin
            emit = 1; l = 1; m_open = 0;
          end
        end
      end
      if (emit) begin
        m_valid = 1; m_res = r; m_zero = (r == 0); m_last = l;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic beat(input logic [2:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic am,
                      input logic lst);
    int n;
    in_valid = 1'b1; op = o; a = x; b = y;
    acc_mode = am; in_last = lst;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      errs++; checks++;
      $display("FAIL beat_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_got(input string nm, input int idx,
                         input int res, input int lst, input int zr);
    if (idx >= got.size()) begin
      errs++; checks++;
      $display("FAIL %s: got no output #%0d expected %0h", nm, idx, res);
    end else begin
      chk({nm, "_res"}, int'(got[idx][7:0]), res);
      chk({nm, "_last"}, int'(got[idx][9]), lst);
      chk({nm, "_zero"}, int'(got[idx][8]), zr);
    end
  endtask

  initial begin
    logic [7:0] exp8 [8];
    exp8 = '{8'hC0, 8'hFC, 8'h3C, 8'h03, 8'h3F, 8'hC3, 8'h30, 8'hF3};

    // Reset held with a beat offered
    rst_n = 1'b0; in_valid = 1'b1; a = 8'h12; b = 8'h34;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;

    // All eight ops back to back
    got.delete();
    for (int o = 0; o < 8; o++) beat(3'(o), 8'hF0, 8'hCC, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("ops_count", got.size(), 8);
    for (int o = 0; o < 8; o++)
      chk_got("op", o, int'(exp8[o]), 0, 0);

    // OR burst folded to one output
    @(posedge clk); #1;
    got.delete();
    beat(3'd1, 8'h01, 8'h02, 1'b1, 1'b0);
    beat(3'd5, 8'h55, 8'h04, 1'b0, 1'b0);
    beat(3'd0, 8'h33, 8'h80, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("burst_count", got.size(), 1);
    chk_got("burst", 0, 'h87, 1, 0);

    // Backpressure for 3 cycles across two AND beats
    @(posedge clk); #1;
    got.delete();
    out_ready = 1'b0;
    fork
      begin
        beat(3'd0, 8'hFF, 8'h0F, 1'b0, 1'b0);
        beat(3'd0, 8'hAA, 8'hF0, 1'b0, 1'b0);
      end
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_held", int'(out_result), 'h0F);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    chk("bp_count", got.size(), 2);
    chk_got("bp0", 0, 'h0F, 0, 0);
    chk_got("bp1", 1, 'hA0, 0, 0);

    // Zero flag
    @(posedge clk); #1;
    got.delete();
    beat(3'd2, 8'h5A, 8'h5A, 1'b0, 1'b0);
    beat(3'd1, 8'h00, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_got("zero_set", 0, 'h00, 0, 1);
    chk_got("zero_clr", 1, 'h01, 0, 0);

    // Reset in the middle of an open burst
    @(posedge clk); #1;
    got.delete();
    beat(3'd2, 8'h3C, 8'h0F, 1'b1, 1'b0);
    beat(3'd2, 8'h00, 8'hF0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_none", got.size(), 0);
    @(posedge clk); #1;
    beat(3'd0, 8'hFF, 8'h0F, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_mid_count", got.size(), 1);
    chk_got("rst_mid", 0, 'h0F, 1, 0);

    // Randomized traffic with random backpressure
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 3'($urandom);
      acc_mode  = 1'($urandom);
      in_last   = ($urandom % 3) == 0;
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
